// File: rtl/spi_byte_xfer_ctrl_if.sv
// Register-bus and launch-side signals of the SPI byte-exchange sequencer.
// master = sequencer side, slave = SPI master core plus message/launch logic.
interface spi_byte_xfer_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  I_TX_EN;
  logic [2:0]            I_WADDR;
  logic [DATA_WIDTH-1:0] I_WDATA;
  logic                  I_RX_EN;
  logic [2:0]            I_RADDR;
  logic [DATA_WIDTH-1:0] O_RDATA;
  logic [DATA_WIDTH-1:0] o_data;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  is_sending;
  logic [7:0]            wr_index;

  modport master (
    input  start, O_RDATA, o_data,
    output I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR, i_data, is_sending, wr_index
  );

  modport slave (
    output start, O_RDATA, o_data,
    input  I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR, i_data, is_sending, wr_index
  );
endinterface

// File: rtl/spi_byte_xfer_ctrl.sv
// Sequencer performing one full-duplex byte exchange per request over the SPI master register bus.
// Optional poll watchdog is enabled by defining SPI_CTRL_TIMEOUT_EN.
module spi_byte_xfer_ctrl #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [2:0]            ADDR_RXDATA = 3'd0,
  parameter logic [2:0]            ADDR_TXDATA = 3'd1,
  parameter logic [2:0]            ADDR_STATUS = 3'd2,
  parameter logic [2:0]            ADDR_SSMASK = 3'd4,
  parameter logic [DATA_WIDTH-1:0] SSMASK_VAL  = 8'h01,
  parameter int                    TRDY_BIT    = 6,
  parameter int                    RRDY_BIT    = 7,
  parameter int                    RD_LAT      = 1,
  parameter logic [15:0]           TIMEOUT     = 16'd50000
) (
  input  logic                 I_CLK,
  input  logic                 I_RESET,
  spi_byte_xfer_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_POLL_T,
    S_WRITE,
    S_POLL_R,
    S_READ,
    S_DONE
  } state_e;

  // Phase counter value on which read data issued at phase 0 is valid on O_RDATA.
  localparam logic [2:0] SAMPLE_CNT = 3'(RD_LAT + 1);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  tx_en_q, tx_en_d;
  logic [2:0]            waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rx_en_q, rx_en_d;
  logic [2:0]            raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] i_data_q, i_data_d;
  logic                  is_sending_q, is_sending_d;
  logic [7:0]            wr_index_q, wr_index_d;
  logic                  poll_ok;

`ifdef SPI_CTRL_TIMEOUT_EN
  logic [15:0]           tmo_q, tmo_d;
`else
  logic [15:0]           unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  assign poll_ok = (state_q == S_POLL_T) ? bus.O_RDATA[TRDY_BIT] : bus.O_RDATA[RRDY_BIT];

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_en_d      = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    rx_en_d      = 1'b0;
    raddr_d      = raddr_q;
    i_data_d     = i_data_q;
    is_sending_d = is_sending_q;
    wr_index_d   = wr_index_q;

    unique case (state_q)
      S_INIT: begin
        tx_en_d = 1'b1;
        waddr_d = ADDR_SSMASK;
        wdata_d = SSMASK_VAL;
        state_d = S_IDLE;
      end

      S_IDLE: begin
        if (bus.start) begin
          is_sending_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_POLL_T;
        end
      end

      // Each poll: strobe at phase 0, test the ready bit RD_LAT+1 edges later, retry from phase 0.
      S_POLL_T, S_POLL_R: begin
        if (cnt_q == '0) begin
          rx_en_d = 1'b1;
          raddr_d = ADDR_STATUS;
          cnt_d   = 3'd1;
        end else if (cnt_q == SAMPLE_CNT) begin
          cnt_d = '0;
          if (poll_ok) begin
            state_d = (state_q == S_POLL_T) ? S_WRITE : S_READ;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_WRITE: begin
        wdata_d = bus.o_data;
        tx_en_d = 1'b1;
        waddr_d = ADDR_TXDATA;
        cnt_d   = '0;
        state_d = S_POLL_R;
      end

      S_READ: begin
        if (cnt_q == '0) begin
          rx_en_d = 1'b1;
          raddr_d = ADDR_RXDATA;
          cnt_d   = 3'd1;
        end else if (cnt_q == SAMPLE_CNT) begin
          i_data_d = bus.O_RDATA;
          cnt_d    = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_DONE: begin
        wr_index_d   = wr_index_q + 8'd1;
        is_sending_d = 1'b0;
        state_d      = S_IDLE;
      end

      default: state_d = S_INIT;
    endcase

`ifdef SPI_CTRL_TIMEOUT_EN
    // Watchdog spans all retries of one poll phase; it is zero whenever a poll state is entered.
    tmo_d = '0;
    if (state_q == S_POLL_T || state_q == S_POLL_R) begin
      tmo_d = tmo_q + 16'd1;
      if (tmo_d == TIMEOUT) begin
        rx_en_d  = 1'b0;
        i_data_d = '1;
        cnt_d    = '0;
        tmo_d    = '0;
        state_d  = S_DONE;
      end
    end
`endif
  end

  // NOTE: sequential state uses <= so every flop samples the same pre-edge values.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      tx_en_q      <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      rx_en_q      <= 1'b0;
      raddr_q      <= '0;
      i_data_q     <= '0;
      is_sending_q <= 1'b0;
      wr_index_q   <= '0;
`ifdef SPI_CTRL_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_en_q      <= tx_en_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      rx_en_q      <= rx_en_d;
      raddr_q      <= raddr_d;
      i_data_q     <= i_data_d;
      is_sending_q <= is_sending_d;
      wr_index_q   <= wr_index_d;
`ifdef SPI_CTRL_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign bus.I_TX_EN    = tx_en_q;
  assign bus.I_WADDR    = waddr_q;
  assign bus.I_WDATA    = wdata_q;
  assign bus.I_RX_EN    = rx_en_q;
  assign bus.I_RADDR    = raddr_q;
  assign bus.i_data     = i_data_q;
  assign bus.is_sending = is_sending_q;
  assign bus.wr_index   = wr_index_q;

endmodule

// File: tb/tb_spi_byte_xfer_ctrl.sv
// Self-checking bench for spi_byte_xfer_ctrl: register-bus slave model plus transfer-level expectations.
// The timeout scenario runs only when SPI_CTRL_TIMEOUT_EN is defined.
module tb_spi_byte_xfer_ctrl;
  localparam int         DW     = 8;
  localparam int         RD_LAT = 1;
  localparam int         TMO    = 20;
  localparam logic [2:0] A_RX   = 3'd0;
  localparam logic [2:0] A_TX   = 3'd1;
  localparam logic [2:0] A_ST   = 3'd2;
  localparam logic [2:0] A_SS   = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_byte_xfer_ctrl_if #(.DATA_WIDTH(DW)) bus();

  spi_byte_xfer_ctrl #(
    .DATA_WIDTH(DW),
    .RD_LAT    (RD_LAT),
    .TIMEOUT   (16'(TMO))
  ) dut (
    .I_CLK  (clk),
    .I_RESET(rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx  = 0;

  // Slave model configuration (written by the tests only).
  int         t_zero    = 0;
  int         r_zero    = 0;
  logic [7:0] rx_byte   = 8'h00;
  logic [7:0] pre_ready = 8'hC0;

  // Slave model observations (written by the slave process only).
  int         n_wr           = 0;
  int         n_rxrd         = 0;
  int         stat_cnt       = 0;
  int         stat_before_tx = 0;
  bit         phase_post     = 1'b0;
  logic [2:0] last_waddr     = '0;
  logic [7:0] last_wdata     = '0;
  logic [7:0] rdata_r        = '0;

  assign bus.O_RDATA = rdata_r;

  // Register-bus slave: status reads report not-ready for a configured number of polls,
  // TX write moves to the RX-wait phase, RX data read ends the exchange.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_post = 1'b0;
      stat_cnt   = 0;
      rdata_r   <= '0;
    end else begin
      if (bus.I_TX_EN) begin
        n_wr++;
        last_waddr = bus.I_WADDR;
        last_wdata = bus.I_WDATA;
        if (bus.I_WADDR == A_TX) begin
          stat_before_tx = stat_cnt;
          phase_post     = 1'b1;
          stat_cnt       = 0;
        end
      end
      if (bus.I_RX_EN) begin
        if (bus.I_RADDR == A_ST) begin
          if (!phase_post) rdata_r <= (stat_cnt < t_zero) ? 8'h00 : pre_ready;
          else             rdata_r <= (stat_cnt < r_zero) ? 8'h40 : 8'hC0;
          stat_cnt++;
        end else if (bus.I_RADDR == A_RX) begin
          rdata_r   <= rx_byte;
          n_rxrd++;
          phase_post = 1'b0;
          stat_cnt   = 0;
        end
      end
    end
  end

  // Bus protocol monitor: strobes mutually exclusive and one cycle wide.
  logic prev_tx = 1'b0;
  logic prev_rx = 1'b0;
  always @(negedge clk) begin
    if (!rst && (bus.I_TX_EN || bus.I_RX_EN)) begin
      n_checks++;
      if ((bus.I_TX_EN && bus.I_RX_EN) || (bus.I_TX_EN && prev_tx) || (bus.I_RX_EN && prev_rx)) begin
        n_fail++;
        $display("FAIL bus_strobe: tx=%b rx=%b prev_tx=%b prev_rx=%b, required exclusive single-cycle strobes",
                 bus.I_TX_EN, bus.I_RX_EN, prev_tx, prev_rx);
      end
    end
    prev_tx = bus.I_TX_EN;
    prev_rx = bus.I_RX_EN;
  end

  // Transfer latency from start sampled to is_sending falling; each poll retry costs one poll period.
  function automatic int exp_latency(input int tz, input int rz);
    return 2 * (RD_LAT + 2) + RD_LAT + 4 + (RD_LAT + 2) * (tz + rz);
  endfunction

  // One request: o_data switches from d0 to d1 when is_sending rises; start held for 'hold' cycles.
  task automatic run_xfer(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] rx,
                          input int tz, input int rz, input int hold, input logic [7:0] rdy,
                          output int lat, output logic [7:0] got);
    t_zero    = tz;
    r_zero    = rz;
    rx_byte   = rx;
    pre_ready = rdy;
    bus.o_data = d0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    lat = 1;
    n_checks++;
    if (bus.is_sending !== 1'b1) begin
      n_fail++;
      $display("FAIL xfer_rise: is_sending=%b, required 1 one cycle after start", bus.is_sending);
    end
    bus.o_data = d1;
    while (bus.is_sending && lat < 3000) begin
      if (lat >= hold) bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    got = bus.i_data;
    lat = lat - 1;
  endtask

  task automatic test_reset();
    int wr0;
    bus.start  = 1'b0;
    bus.o_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.I_TX_EN !== 1'b0 || bus.I_RX_EN !== 1'b0 || bus.is_sending !== 1'b0 ||
        bus.wr_index !== 8'd0 || bus.i_data !== 8'd0 || bus.I_WDATA !== 8'd0 ||
        bus.I_WADDR !== 3'd0 || bus.I_RADDR !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_values: tx=%b rx=%b snd=%b idx=%h idata=%h wdata=%h waddr=%h raddr=%h, required all zero",
               bus.I_TX_EN, bus.I_RX_EN, bus.is_sending, bus.wr_index, bus.i_data,
               bus.I_WDATA, bus.I_WADDR, bus.I_RADDR);
    end
    wr0 = n_wr;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_wr - wr0 !== 1) begin
      n_fail++;
      $display("FAIL init_write_count: got %0d writes, required 1 within 3 cycles", n_wr - wr0);
    end
    n_checks++;
    if (last_waddr !== A_SS || last_wdata !== 8'h01) begin
      n_fail++;
      $display("FAIL init_write: addr=%0d data=%h, required addr=4 data=01", last_waddr, last_wdata);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_wr - wr0 !== 1 || bus.is_sending !== 1'b0 || bus.wr_index !== 8'd0) begin
      n_fail++;
      $display("FAIL init_idle: writes=%0d snd=%b idx=%0d, required 1, 0, 0",
               n_wr - wr0, bus.is_sending, bus.wr_index);
    end
    exp_idx = 0;
  endtask

  task automatic test_basic_xfer();
    int lat, wr0, rd0;
    logic [7:0] got;
    wr0 = n_wr;
    rd0 = n_rxrd;
    run_xfer(8'h4D, 8'h41, 8'h5A, 0, 0, 1, 8'hC0, lat, got);
    exp_idx = (exp_idx + 1) % 256;
    n_checks++;
    if (lat !== exp_latency(0, 0)) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles, required %0d", lat, exp_latency(0, 0));
    end
    n_checks++;
    if (n_wr - wr0 !== 1 || last_waddr !== A_TX || last_wdata !== 8'h41) begin
      n_fail++;
      $display("FAIL basic_tx_write: writes=%0d addr=%0d data=%h, required 1 write addr=1 data=41",
               n_wr - wr0, last_waddr, last_wdata);
    end
    n_checks++;
    if (got !== 8'h5A || n_rxrd - rd0 !== 1) begin
      n_fail++;
      $display("FAIL basic_rx: i_data=%h rx_reads=%0d, required 5a and 1", got, n_rxrd - rd0);
    end
    n_checks++;
    if (bus.wr_index !== 8'(exp_idx)) begin
      n_fail++;
      $display("FAIL basic_wr_index: got %0d, required %0d", bus.wr_index, exp_idx);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.i_data !== 8'h5A || bus.is_sending !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: i_data=%h snd=%b, required 5a held and idle", bus.i_data, bus.is_sending);
    end
  endtask

  task automatic test_poll_retry();
    int lat, wr0;
    logic [7:0] got;
    wr0 = n_wr;
    run_xfer(8'h10, 8'h92, 8'hE7, 5, 0, 1, 8'h40, lat, got);
    exp_idx = (exp_idx + 1) % 256;
    n_checks++;
    if (stat_before_tx !== 6) begin
      n_fail++;
      $display("FAIL retry_status_reads: got %0d status reads before TX write, required 6", stat_before_tx);
    end
    n_checks++;
    if (n_wr - wr0 !== 1 || last_wdata !== 8'h92) begin
      n_fail++;
      $display("FAIL retry_tx_write: writes=%0d data=%h, required 1 and 92", n_wr - wr0, last_wdata);
    end
    n_checks++;
    if (lat !== exp_latency(5, 0) || got !== 8'hE7) begin
      n_fail++;
      $display("FAIL retry_result: latency=%0d i_data=%h, required %0d and e7", lat, got, exp_latency(5, 0));
    end
  endtask

  task automatic test_back_to_back();
    int rises, falls, low_run, min_gap, cyc, extra;
    logic prev;
    t_zero = 0; r_zero = 0; pre_ready = 8'hC0; rx_byte = 8'h3C;
    @(negedge clk);
    bus.start = 1'b1;
    prev = bus.is_sending;
    rises = 0; falls = 0; low_run = 0; min_gap = 1000; cyc = 0;
    while (falls < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (bus.is_sending && !prev) begin
        rises++;
        if (rises > 1 && low_run < min_gap) min_gap = low_run;
      end
      if (!bus.is_sending && prev) begin
        falls++;
        if (falls == 3) bus.start = 1'b0;
      end
      low_run = bus.is_sending ? 0 : low_run + 1;
      prev = bus.is_sending;
    end
    bus.start = 1'b0;
    exp_idx = (exp_idx + 3) % 256;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.is_sending) extra++;
    end
    n_checks++;
    if (rises !== 3 || falls !== 3 || extra !== 0) begin
      n_fail++;
      $display("FAIL b2b_pulses: rises=%0d falls=%0d extra_high=%0d, required 3, 3, 0", rises, falls, extra);
    end
    n_checks++;
    if (min_gap < 1) begin
      n_fail++;
      $display("FAIL b2b_gap: min low gap %0d cycles, required at least 1", min_gap);
    end
    n_checks++;
    if (bus.wr_index !== 8'(exp_idx)) begin
      n_fail++;
      $display("FAIL b2b_wr_index: got %0d, required %0d", bus.wr_index, exp_idx);
    end
  endtask

  task automatic test_random();
    int lat, tz, rz, hold, wr0, lowcnt;
    logic [7:0] d0, d1, rx, got;
    for (int i = 0; i < 8; i++) begin
      d0   = 8'($urandom);
      d1   = 8'($urandom);
      if (d1 == d0) d1 = d0 ^ 8'h01;
      rx   = 8'($urandom);
      tz   = int'($urandom_range(0, 3));
      rz   = int'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 5));
      wr0  = n_wr;
      run_xfer(d0, d1, rx, tz, rz, hold, 8'hC0, lat, got);
      exp_idx = (exp_idx + 1) % 256;
      n_checks++;
      if (lat !== exp_latency(tz, rz) || stat_before_tx !== tz + 1) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: latency=%0d status_reads=%0d, required %0d and %0d",
                 i, lat, stat_before_tx, exp_latency(tz, rz), tz + 1);
      end
      n_checks++;
      if (n_wr - wr0 !== 1 || last_waddr !== A_TX || last_wdata !== d1 || got !== rx) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: writes=%0d addr=%0d wdata=%h i_data=%h, required 1, 1, %h, %h",
                 i, n_wr - wr0, last_waddr, last_wdata, got, d1, rx);
      end
      lowcnt = 0;
      repeat (3) begin
        @(negedge clk);
        if (!bus.is_sending) lowcnt++;
      end
      n_checks++;
      if (lowcnt !== 3 || bus.wr_index !== 8'(exp_idx)) begin
        n_fail++;
        $display("FAIL rand_after[%0d]: idle_cycles=%0d wr_index=%0d, required 3 and %0d",
                 i, lowcnt, bus.wr_index, exp_idx);
      end
    end
  endtask

  task automatic test_reset_mid_xfer();
    int wr0, cyc;
    t_zero = 0; r_zero = 50; pre_ready = 8'hC0; rx_byte = 8'h66;
    wr0 = n_wr;
    @(negedge clk);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.o_data = 8'h77;
    cyc = 0;
    while (n_wr == wr0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (n_wr - wr0 !== 1 || bus.is_sending !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_setup: writes=%0d snd=%b, required 1 TX write and busy", n_wr - wr0, bus.is_sending);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.is_sending !== 1'b0 || bus.i_data !== 8'd0 || bus.wr_index !== 8'd0 ||
        bus.I_TX_EN !== 1'b0 || bus.I_RX_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_abort: snd=%b i_data=%h idx=%0d tx=%b rx=%b, required all zero",
               bus.is_sending, bus.i_data, bus.wr_index, bus.I_TX_EN, bus.I_RX_EN);
    end
    exp_idx = 0;
    r_zero  = 0;
    @(negedge clk);
    wr0 = n_wr;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_wr - wr0 !== 1 || last_waddr !== A_SS || last_wdata !== 8'h01 || bus.i_data !== 8'd0) begin
      n_fail++;
      $display("FAIL midrst_reinit: writes=%0d addr=%0d data=%h i_data=%h, required 1, 4, 01, 00",
               n_wr - wr0, last_waddr, last_wdata, bus.i_data);
    end
  endtask

  task automatic test_wrap();
    int needed, falls, cyc;
    logic prev;
    logic [7:0] idx_before;
    t_zero = 0; r_zero = 0; pre_ready = 8'hC0; rx_byte = 8'hA5;
    needed = 256 - exp_idx;
    idx_before = 8'h00;
    @(negedge clk);
    bus.start = 1'b1;
    prev = bus.is_sending;
    falls = 0; cyc = 0;
    while (falls < needed && cyc < 256 * 30) begin
      @(negedge clk);
      cyc++;
      if (!bus.is_sending && prev) begin
        falls++;
        if (falls == needed - 1) idx_before = bus.wr_index;
        if (falls == needed) bus.start = 1'b0;
      end
      prev = bus.is_sending;
    end
    bus.start = 1'b0;
    exp_idx = (exp_idx + needed) % 256;
    n_checks++;
    if (idx_before !== 8'd255) begin
      n_fail++;
      $display("FAIL wrap_255: wr_index=%0d, required 255", idx_before);
    end
    n_checks++;
    if (bus.wr_index !== 8'(exp_idx) || falls !== needed) begin
      n_fail++;
      $display("FAIL wrap_0: wr_index=%0d transfers=%0d, required %0d and %0d",
               bus.wr_index, falls, exp_idx, needed);
    end
    repeat (4) @(negedge clk);
  endtask

`ifdef SPI_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int lat, wr0;
    logic [7:0] got;
    wr0 = n_wr;
    run_xfer(8'h01, 8'h02, 8'h5A, 100000, 0, 1, 8'hC0, lat, got);
    exp_idx = (exp_idx + 1) % 256;
    t_zero = 0;
    n_checks++;
    if (lat < TMO || lat > TMO + 3) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles, required %0d..%0d", lat, TMO, TMO + 3);
    end
    n_checks++;
    if (got !== 8'hFF || n_wr - wr0 !== 0 || bus.wr_index !== 8'(exp_idx)) begin
      n_fail++;
      $display("FAIL timeout_result: i_data=%h writes=%0d idx=%0d, required ff, 0, %0d",
               got, n_wr - wr0, bus.wr_index, exp_idx);
    end
  endtask
`endif

  initial begin
    bus.start  = 1'b0;
    bus.o_data = 8'h00;
    test_reset();
    test_basic_xfer();
    test_poll_retry();
    test_back_to_back();
    test_random();
    test_reset_mid_xfer();
    test_wrap();
`ifdef SPI_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_byte_xfer_ctrl.md
Name: spi_byte_xfer_ctrl

Overview:
- Sequencer that performs one full-duplex byte exchange per request through the register interface of the SPI master core.
- Sits between the message/launch logic (start, o_data, i_data, is_sending) and the SPI master register bus (I_TX_EN/I_WADDR/I_WDATA, I_RX_EN/I_RADDR/O_RDATA).
- Per transfer: poll status, write the TX byte, poll for RX-ready, read the RX byte, report completion.

Parameters:
- DATA_WIDTH, 8: width of the TX/RX data and of the register bus.
- ADDR_RXDATA, 3'd0: RX data register address.
- ADDR_TXDATA, 3'd1: TX data register address.
- ADDR_STATUS, 3'd2: status register address.
- ADDR_SSMASK, 3'd4: slave-select mask register address.
- SSMASK_VAL, 8'h01: value written to the slave-select mask after reset.
- TRDY_BIT, 6: status bit meaning "TX register ready".
- RRDY_BIT, 7: status bit meaning "RX data ready".
- RD_LAT, 1: cycles from an I_RX_EN pulse until O_RDATA is valid (legal range 1..3).
- TIMEOUT, 16'd50000: poll limit; used only with the optional feature.

Ports:
- I_CLK, in, 1: clock; all logic is on the rising edge.
- I_RESET, in, 1: asynchronous, active-high reset.
- start, in, 1: transfer request, level-sensitive, sampled only in IDLE.
- I_TX_EN, out, 1: one-cycle register write strobe.
- I_WADDR, out, 3: register write address.
- I_WDATA, out, DATA_WIDTH: register write data.
- I_RX_EN, out, 1: one-cycle register read strobe.
- I_RADDR, out, 3: register read address.
- O_RDATA, in, DATA_WIDTH: register read data, valid RD_LAT cycles after I_RX_EN.
- o_data, in, DATA_WIDTH: byte to transmit.
- i_data, out, DATA_WIDTH: last received byte; held between transfers.
- is_sending, out, 1: high while a transfer is in progress.
- wr_index, out, 8: count of completed transfers; wraps 255 to 0.

Behaviour:
- Reset values (asserted asynchronously):
  - All strobes = 0.
  - I_WADDR = I_RADDR = 0.
  - I_WDATA = 0, i_data = 0, wr_index = 0.
  - is_sending = 0.
  - State = INIT.
- INIT (only after reset):
  - Issue one write of SSMASK_VAL to ADDR_SSMASK.
  - Then go to IDLE.
  - start is ignored in INIT.
- IDLE:
  - If start = 1, set is_sending = 1 on the next edge and go to POLL_T.
  - start held high after completion begins a new transfer. The caller drops start on seeing is_sending.
- POLL_T:
  - Pulse I_RX_EN with I_RADDR = ADDR_STATUS.
  - Wait RD_LAT cycles, then test O_RDATA[TRDY_BIT].
  - If 1, go to WRITE. If 0, re-poll.
- WRITE:
  - Sample o_data into I_WDATA.
  - Pulse I_TX_EN with I_WADDR = ADDR_TXDATA.
  - o_data is sampled no earlier than 2 cycles after is_sending rises, because the caller updates o_data on the rising edge of is_sending.
- POLL_R:
  - Same polling as POLL_T, but test RRDY_BIT.
  - On 1, go to READ.
- READ:
  - Pulse I_RX_EN with I_RADDR = ADDR_RXDATA.
  - After RD_LAT cycles, register O_RDATA into i_data.
- DONE (one cycle):
  - wr_index increments.
  - is_sending = 0.
  - Return to IDLE.
  - i_data is valid no later than the edge on which is_sending falls.
- Bus rules:
  - I_TX_EN and I_RX_EN are never high in the same cycle.
  - Each strobe is exactly one cycle wide.
  - Address and data are stable during the strobe cycle.
- start asserted mid-transfer has no effect.
- Reset mid-transfer:
  - Immediate abort; outputs return to reset values.
  - INIT repeats after reset is released.
- Minimum transfer latency, from start sampled to is_sending falling: 2*(RD_LAT+2)+RD_LAT+4 cycles, with no poll retries.

Optional Feature:
- Macro: SPI_CTRL_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to POLL_T and POLL_R and increments every cycle in those states.
  - On reaching TIMEOUT, abort the transfer: i_data = all ones, go to DONE. wr_index still increments and is_sending falls.
- When undefined:
  - Polling retries indefinitely.
  - No counter logic is synthesised.

Test Plan:
- Reset release -> exactly one write, addr 4, data 8'h01, within 3 cycles; is_sending = 0, wr_index = 0.
- start pulse, o_data changes 8'h4D→8'h41 on the is_sending rise, slave model returns status 8'hC0 and RX 8'h5A:
  - TX write shows data 8'h41 at addr 1.
  - i_data = 8'h5A when is_sending falls.
  - wr_index = 1.
- Status returns 8'h00 for 5 polls, then 8'h40 -> exactly 6 status reads before the TX write; no TX write while TRDY = 0.
- start held high for 3 transfers -> three separate is_sending pulses, each ≥1 cycle low between; wr_index = 3.
- I_RESET asserted during POLL_R -> is_sending = 0 immediately; SSMASK write repeats after release; i_data = 0.
- SPI_CTRL_TIMEOUT_EN with TIMEOUT = 20, status stuck at 8'h00 -> is_sending falls about 20 cycles into POLL_T; i_data = 8'hFF.
